// File: rtl/kb_codes_pkg.sv
// Shared PS/2 Set-2 scan-code constants, encoder state type and lookup result.
// The receive-side scan-code-to-ASCII converter imports the same constants.
package kb_codes_pkg;

  localparam logic [7:0] KC_A = 8'h1C, KC_B = 8'h32, KC_C = 8'h21, KC_D = 8'h23;
  localparam logic [7:0] KC_E = 8'h24, KC_F = 8'h2B, KC_G = 8'h34, KC_H = 8'h33;
  localparam logic [7:0] KC_I = 8'h43, KC_J = 8'h3B, KC_K = 8'h42, KC_L = 8'h4B;
  localparam logic [7:0] KC_M = 8'h3A, KC_N = 8'h31, KC_O = 8'h44, KC_P = 8'h4D;
  localparam logic [7:0] KC_Q = 8'h15, KC_R = 8'h2D, KC_S = 8'h1B, KC_T = 8'h2C;
  localparam logic [7:0] KC_U = 8'h3C, KC_V = 8'h2A, KC_W = 8'h1D, KC_X = 8'h22;
  localparam logic [7:0] KC_Y = 8'h35, KC_Z = 8'h1A;

  localparam logic [7:0] KC_0 = 8'h45, KC_1 = 8'h16, KC_2 = 8'h1E, KC_3 = 8'h26;
  localparam logic [7:0] KC_4 = 8'h25, KC_5 = 8'h2E, KC_6 = 8'h36, KC_7 = 8'h3D;
  localparam logic [7:0] KC_8 = 8'h3E, KC_9 = 8'h46;

  localparam logic [7:0] KC_GRAVE  = 8'h0E, KC_MINUS  = 8'h4E, KC_EQUAL  = 8'h55;
  localparam logic [7:0] KC_LBRACK = 8'h54, KC_RBRACK = 8'h5B, KC_BSLASH = 8'h5D;
  localparam logic [7:0] KC_SEMI   = 8'h4C, KC_QUOTE  = 8'h52, KC_COMMA  = 8'h41;
  localparam logic [7:0] KC_PERIOD = 8'h49, KC_SLASH  = 8'h4A, KC_SPACE  = 8'h29;
  localparam logic [7:0] KC_ENTER  = 8'h5A, KC_BKSP   = 8'h66, KC_TAB    = 8'h0D;
  localparam logic [7:0] KC_LSHIFT = 8'h12, KC_BREAK  = 8'hF0;

  typedef enum logic [2:0] {
    IDLE, SH_MK, KEY_MK, KEY_BP, KEY_BK, SH_BP, SH_BK, GAP
  } kb_state_e;

  typedef struct packed {
    logic [7:0] key_code;
    logic       needs_shift;
    logic       supported;
  } kb_lookup_t;

  function automatic logic [7:0] letter_code(input logic [4:0] idx);
    case (idx)
      5'd0:  return KC_A;  5'd1:  return KC_B;  5'd2:  return KC_C;
      5'd3:  return KC_D;  5'd4:  return KC_E;  5'd5:  return KC_F;
      5'd6:  return KC_G;  5'd7:  return KC_H;  5'd8:  return KC_I;
      5'd9:  return KC_J;  5'd10: return KC_K;  5'd11: return KC_L;
      5'd12: return KC_M;  5'd13: return KC_N;  5'd14: return KC_O;
      5'd15: return KC_P;  5'd16: return KC_Q;  5'd17: return KC_R;
      5'd18: return KC_S;  5'd19: return KC_T;  5'd20: return KC_U;
      5'd21: return KC_V;  5'd22: return KC_W;  5'd23: return KC_X;
      5'd24: return KC_Y;  5'd25: return KC_Z;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] digit_code(input logic [3:0] idx);
    case (idx)
      4'd0: return KC_0;  4'd1: return KC_1;  4'd2: return KC_2;
      4'd3: return KC_3;  4'd4: return KC_4;  4'd5: return KC_5;
      4'd6: return KC_6;  4'd7: return KC_7;  4'd8: return KC_8;
      4'd9: return KC_9;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/ascii_to_kb_lookup.sv
// Combinational ASCII -> Set-2 key lookup: key code, whether Shift is held,
// and whether the character can be typed at all.
module ascii_to_kb_lookup
  import kb_codes_pkg::*;
(
  input  logic [7:0] ascii_in,
  output kb_lookup_t lk
);

  function automatic kb_lookup_t mk(input logic [7:0] code, input logic sh);
    return '{key_code: code, needs_shift: sh, supported: 1'b1};
  endfunction

  always_comb begin
    lk = '{key_code: 8'h00, needs_shift: 1'b0, supported: 1'b0};
    if (ascii_in >= 8'h61 && ascii_in <= 8'h7A) begin
      lk = mk(letter_code(5'(ascii_in - 8'h61)), 1'b0);
    end else if (ascii_in >= 8'h41 && ascii_in <= 8'h5A) begin
      lk = mk(letter_code(5'(ascii_in - 8'h41)), 1'b1);
    end else if (ascii_in >= 8'h30 && ascii_in <= 8'h39) begin
      lk = mk(digit_code(4'(ascii_in - 8'h30)), 1'b0);
    end else begin
      case (ascii_in)
        8'h60: lk = mk(KC_GRAVE,  1'b0);  8'h7E: lk = mk(KC_GRAVE,  1'b1);
        8'h2D: lk = mk(KC_MINUS,  1'b0);  8'h5F: lk = mk(KC_MINUS,  1'b1);
        8'h3D: lk = mk(KC_EQUAL,  1'b0);  8'h2B: lk = mk(KC_EQUAL,  1'b1);
        8'h5B: lk = mk(KC_LBRACK, 1'b0);  8'h7B: lk = mk(KC_LBRACK, 1'b1);
        8'h5D: lk = mk(KC_RBRACK, 1'b0);  8'h7D: lk = mk(KC_RBRACK, 1'b1);
        8'h5C: lk = mk(KC_BSLASH, 1'b0);  8'h7C: lk = mk(KC_BSLASH, 1'b1);
        8'h3B: lk = mk(KC_SEMI,   1'b0);  8'h3A: lk = mk(KC_SEMI,   1'b1);
        8'h27: lk = mk(KC_QUOTE,  1'b0);  8'h22: lk = mk(KC_QUOTE,  1'b1);
        8'h2C: lk = mk(KC_COMMA,  1'b0);  8'h3C: lk = mk(KC_COMMA,  1'b1);
        8'h2E: lk = mk(KC_PERIOD, 1'b0);  8'h3E: lk = mk(KC_PERIOD, 1'b1);
        8'h2F: lk = mk(KC_SLASH,  1'b0);  8'h3F: lk = mk(KC_SLASH,  1'b1);
        // Shifted digit row: ! @ # $ % ^ & * ( )
        8'h21: lk = mk(KC_1, 1'b1);  8'h40: lk = mk(KC_2, 1'b1);
        8'h23: lk = mk(KC_3, 1'b1);  8'h24: lk = mk(KC_4, 1'b1);
        8'h25: lk = mk(KC_5, 1'b1);  8'h5E: lk = mk(KC_6, 1'b1);
        8'h26: lk = mk(KC_7, 1'b1);  8'h2A: lk = mk(KC_8, 1'b1);
        8'h28: lk = mk(KC_9, 1'b1);  8'h29: lk = mk(KC_0, 1'b1);
        8'h20: lk = mk(KC_SPACE, 1'b0);
        8'h0A: lk = mk(KC_ENTER, 1'b0);
        8'h0D: lk = mk(KC_ENTER, 1'b0);
        8'h08: lk = mk(KC_BKSP,  1'b0);
        8'h09: lk = mk(KC_TAB,   1'b0);
        default: lk = '{key_code: 8'h00, needs_shift: 1'b0, supported: 1'b0};
      endcase
    end
  end

endmodule

// File: rtl/ascii_kb_code_encoder.sv
// Turns one accepted ASCII character into its PS/2 Set-2 make/break byte
// sequence (with Left-Shift wrapping), one byte per valid/ready handshake.
module ascii_kb_code_encoder
  import kb_codes_pkg::*;
#(
  parameter logic [7:0] SHIFT_CODE   = 8'h12,
  parameter logic [7:0] BREAK_PREFIX = 8'hF0,
  parameter int         GAP_CYCLES   = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ascii_in,
  input  logic       ascii_valid,
  output logic       ascii_ready,
  output logic [7:0] code_out,
  output logic       code_valid,
  input  logic       code_ready,
  output logic       unsupported,
  output logic       busy
);

  localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

  kb_lookup_t lk;

  kb_state_e        state_q, state_d;
  kb_state_e        ret_q, ret_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [7:0]       key_q, key_d;
  logic             shift_q, shift_d;
  logic [7:0]       code_out_q, code_out_d;
  logic             code_valid_q, code_valid_d;
  logic             ascii_ready_q, ascii_ready_d;
  logic             unsupported_q, unsupported_d;
  logic             busy_q, busy_d;
  kb_state_e        adv;

  ascii_to_kb_lookup u_lookup (
    .ascii_in (ascii_in),
    .lk       (lk)
  );

  function automatic kb_state_e seq_next(input kb_state_e s, input logic sh);
    case (s)
      SH_MK:   return KEY_MK;
      KEY_MK:  return KEY_BP;
      KEY_BP:  return KEY_BK;
      KEY_BK:  return sh ? SH_BP : IDLE;
      SH_BP:   return SH_BK;
      default: return IDLE;
    endcase
  endfunction

  function automatic logic is_byte_state(input kb_state_e s);
    return (s != IDLE) && (s != GAP);
  endfunction

  function automatic logic [7:0] byte_for(input kb_state_e s, input logic [7:0] key);
    case (s)
      SH_MK, SH_BK:   return SHIFT_CODE;
      KEY_MK, KEY_BK: return key;
      KEY_BP, SH_BP:  return BREAK_PREFIX;
      default:        return 8'h00;
    endcase
  endfunction

  always_comb begin
    state_d       = state_q;
    ret_d         = ret_q;
    gap_d         = gap_q;
    key_d         = key_q;
    shift_d       = shift_q;
    unsupported_d = 1'b0;
    adv           = IDLE;

    case (state_q)
      IDLE: begin
        if (ascii_valid && ascii_ready_q) begin
          key_d   = lk.key_code;
          shift_d = lk.needs_shift;
          if (!lk.supported) begin
            unsupported_d = 1'b1;
          end else begin
            state_d = lk.needs_shift ? SH_MK : KEY_MK;
          end
        end
      end
      GAP: begin
        if (gap_q == '0) begin
          state_d = ret_q;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end
      default: begin
        if (code_valid_q && code_ready) begin
          adv = seq_next(state_q, shift_q);
          if (GAP_CYCLES > 0) begin
            state_d = GAP;
            ret_d   = adv;
            gap_d   = GAP_LOAD;
          end else begin
            state_d = adv;
          end
        end
      end
    endcase

    // Outputs are registered views of the next state, so they line up with state_q.
    code_valid_d  = is_byte_state(state_d);
    code_out_d    = is_byte_state(state_d) ? byte_for(state_d, key_d) : code_out_q;
    ascii_ready_d = (state_d == IDLE);
    busy_d        = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      ret_q         <= IDLE;
      gap_q         <= '0;
      key_q         <= 8'h00;
      shift_q       <= 1'b0;
      code_out_q    <= 8'h00;
      code_valid_q  <= 1'b0;
      ascii_ready_q <= 1'b1;
      unsupported_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      ret_q         <= ret_d;
      gap_q         <= gap_d;
      key_q         <= key_d;
      shift_q       <= shift_d;
      code_out_q    <= code_out_d;
      code_valid_q  <= code_valid_d;
      ascii_ready_q <= ascii_ready_d;
      unsupported_q <= unsupported_d;
      busy_q        <= busy_d;
    end
  end

  assign ascii_ready = ascii_ready_q;
  assign code_out    = code_out_q;
  assign code_valid  = code_valid_q;
  assign unsupported = unsupported_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_ascii_kb_code_encoder.sv
// Bench for ascii_kb_code_encoder: a no-gap and a 3-cycle-gap instance, checked
// against a table-driven keystroke model.
module tb_ascii_kb_code_encoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] ascii_in = 8'h00;
  logic       ascii_valid = 1'b0;
  logic       code_ready = 1'b0;
  logic       sel = 1'b0;

  logic       r0, cv0, u0, b0, r1, cv1, u1, b1;
  logic [7:0] co0, co1;
  logic       o_ready, o_cv, o_unsup, o_busy;
  logic [7:0] o_co;

  always #5 clk = ~clk;

  ascii_kb_code_encoder #(.GAP_CYCLES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .ascii_in(ascii_in), .ascii_valid(ascii_valid && !sel),
    .ascii_ready(r0), .code_out(co0), .code_valid(cv0), .code_ready(code_ready),
    .unsupported(u0), .busy(b0)
  );

  ascii_kb_code_encoder #(.GAP_CYCLES(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .ascii_in(ascii_in), .ascii_valid(ascii_valid && sel),
    .ascii_ready(r1), .code_out(co1), .code_valid(cv1), .code_ready(code_ready),
    .unsupported(u1), .busy(b1)
  );

  assign o_ready = sel ? r1  : r0;
  assign o_cv    = sel ? cv1 : cv0;
  assign o_co    = sel ? co1 : co0;
  assign o_unsup = sel ? u1  : u0;
  assign o_busy  = sel ? b1  : b0;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [47:0] got_vec;
  int          got_len;
  int          hs_cyc[$];
  int          end_cyc, unsup_cnt, first_valid_cyc;
  bit          saw_busy;

  // Keystroke model: position in the typed-character tables selects the key.
  task automatic model(input logic [7:0] ch, output logic [47:0] vec,
                       output int len, output bit sup);
    string      lo, hi;
    logic [7:0] keys [47];
    logic [7:0] kc;
    bit         sh;
    lo = "abcdefghijklmnopqrstuvwxyz1234567890`-=[]|;',./";
    hi = "ABCDEFGHIJKLMNOPQRSTUVWXYZ!@#$%^&*()~_+{}|:X<>?";
    lo[41] = 8'h5C;
    hi[43] = 8'h22;
    keys = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B,
             8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C,
             8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A,
             8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46, 8'h45,
             8'h0E, 8'h4E, 8'h55, 8'h54, 8'h5B, 8'h5D, 8'h4C, 8'h52, 8'h41, 8'h49, 8'h4A};
    sup = 1'b0; sh = 1'b0; kc = 8'h00;
    for (int i = 0; i < 47; i++) begin
      if (lo[i] == ch) begin sup = 1'b1; sh = 1'b0; kc = keys[i]; end
      if (hi[i] == ch) begin sup = 1'b1; sh = 1'b1; kc = keys[i]; end
    end
    if (ch == 8'h20) begin sup = 1'b1; kc = 8'h29; end
    if (ch == 8'h0A || ch == 8'h0D) begin sup = 1'b1; kc = 8'h5A; end
    if (ch == 8'h08) begin sup = 1'b1; kc = 8'h66; end
    if (ch == 8'h09) begin sup = 1'b1; kc = 8'h0D; end
    if (!sup) begin
      len = 0; vec = '0;
    end else if (sh) begin
      len = 6; vec = {8'h12, kc, 8'hF0, kc, 8'hF0, 8'h12};
    end else begin
      len = 3; vec = {24'h0, kc, 8'hF0, kc};
    end
  endtask

  // mode 0: ready held high; 1: ready pattern 1,0,0 repeating; 2: random ready and input noise
  task automatic run_char(input logic [7:0] ch, input int mode);
    int         guard;
    logic       pv, pr;
    logic [7:0] po;
    got_vec = '0; got_len = 0; hs_cyc.delete();
    end_cyc = -1; unsup_cnt = 0; first_valid_cyc = -1; saw_busy = 1'b0;
    guard = 0;
    while (!o_ready && guard < 100) begin @(negedge clk); guard++; end
    n_checks++;
    if (o_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL ready_wait: ascii_ready=%b required 1 before char %h", o_ready, ch);
    end
    ascii_in = ch; ascii_valid = 1'b1;
    @(negedge clk);
    ascii_valid = 1'b0; ascii_in = 8'($urandom);
    pv = 1'b0; pr = 1'b0; po = 8'h00;
    for (int c = 0; c < 200; c++) begin
      if (pv && !pr) begin
        n_checks++;
        if (o_cv !== 1'b1 || o_co !== po) begin
          n_errors++;
          $display("FAIL hold: valid=%b code=%h, required valid=1 code=%h", o_cv, o_co, po);
        end
      end
      if (o_unsup) unsup_cnt++;
      if (o_busy) saw_busy = 1'b1;
      if (o_cv && first_valid_cyc < 0) first_valid_cyc = c;
      if (o_ready) begin
        ascii_valid = 1'b0;
        end_cyc = c;
        break;
      end
      case (mode)
        0:       code_ready = 1'b1;
        1:       code_ready = (c % 3 == 0);
        default: begin
          code_ready  = 1'($urandom);
          ascii_valid = 1'($urandom);
          ascii_in    = 8'($urandom);
        end
      endcase
      if (o_cv && code_ready) begin
        got_vec = {got_vec[39:0], o_co};
        got_len++;
        hs_cyc.push_back(c);
      end
      pv = o_cv; pr = code_ready; po = o_co;
      @(negedge clk);
    end
    n_checks++;
    if (end_cyc < 0) begin
      n_errors++;
      $display("FAIL timeout: char %h never returned to ascii_ready=1", ch);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (o_ready !== 1'b1) begin n_errors++; $display("FAIL rst_ready: %b required 1", o_ready); end
    n_checks++;
    if (o_cv !== 1'b0) begin n_errors++; $display("FAIL rst_valid: %b required 0", o_cv); end
    n_checks++;
    if (o_co !== 8'h00) begin n_errors++; $display("FAIL rst_code: %h required 00", o_co); end
    n_checks++;
    if (o_unsup !== 1'b0) begin n_errors++; $display("FAIL rst_unsup: %b required 0", o_unsup); end
    n_checks++;
    if (o_busy !== 1'b0) begin n_errors++; $display("FAIL rst_busy: %b required 0", o_busy); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_plain();
    logic [47:0] ev; int el; bit es;
    run_char(8'h61, 0);
    model(8'h61, ev, el, es);
    n_checks++;
    if (got_vec !== ev || got_len != el) begin
      n_errors++;
      $display("FAIL plain_a: got %0d bytes %h, required %0d bytes %h", got_len, got_vec, el, ev);
    end
    n_checks++;
    if (first_valid_cyc != 0) begin
      n_errors++; $display("FAIL plain_latency: first valid at %0d required 0", first_valid_cyc);
    end
    n_checks++;
    if (hs_cyc.size() != 3 || hs_cyc[2] != 2 || end_cyc != 3) begin
      n_errors++; $display("FAIL plain_timing: %0d handshakes, ready back at %0d required 3", hs_cyc.size(), end_cyc);
    end
    n_checks++;
    if (unsup_cnt != 0) begin n_errors++; $display("FAIL plain_unsup: %0d pulses required 0", unsup_cnt); end
  endtask

  task automatic test_shift();
    logic [7:0] chars [2];
    logic [47:0] ev; int el; bit es;
    chars = '{8'h41, 8'h21};
    foreach (chars[i]) begin
      run_char(chars[i], 0);
      model(chars[i], ev, el, es);
      n_checks++;
      if (got_vec !== ev || got_len != el) begin
        n_errors++;
        $display("FAIL shift_%h: got %0d bytes %h, required %0d bytes %h", chars[i], got_len, got_vec, el, ev);
      end
      n_checks++;
      if (hs_cyc.size() != 6 || end_cyc != 6) begin
        n_errors++; $display("FAIL shift_timing_%h: ready back at %0d required 6", chars[i], end_cyc);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [47:0] ev; int el; bit es;
    run_char(8'h7A, 1);
    model(8'h7A, ev, el, es);
    n_checks++;
    if (got_vec !== ev || got_len != el) begin
      n_errors++;
      $display("FAIL backpressure_z: got %0d bytes %h, required %0d bytes %h", got_len, got_vec, el, ev);
    end
  endtask

  task automatic test_unsupported();
    logic [7:0] chars [2];
    chars = '{8'h7F, 8'h80};
    foreach (chars[i]) begin
      run_char(chars[i], 0);
      n_checks++;
      if (unsup_cnt != 1) begin n_errors++; $display("FAIL unsup_pulse_%h: %0d required 1", chars[i], unsup_cnt); end
      n_checks++;
      if (got_len != 0 || first_valid_cyc != -1) begin
        n_errors++; $display("FAIL unsup_bytes_%h: %0d bytes required 0", chars[i], got_len);
      end
      n_checks++;
      if (saw_busy) begin n_errors++; $display("FAIL unsup_busy_%h: busy=1 required 0", chars[i]); end
      @(negedge clk);
      n_checks++;
      if (o_unsup !== 1'b0) begin n_errors++; $display("FAIL unsup_width_%h: still %b required 0", chars[i], o_unsup); end
    end
  endtask

  task automatic test_gap();
    logic [47:0] ev; int el; bit es;
    sel = 1'b1;
    run_char(8'h0A, 0);
    model(8'h0A, ev, el, es);
    n_checks++;
    if (got_vec !== ev || got_len != el) begin
      n_errors++;
      $display("FAIL gap_seq: got %0d bytes %h, required %0d bytes %h", got_len, got_vec, el, ev);
    end
    n_checks++;
    if (hs_cyc.size() != 3) begin
      n_errors++; $display("FAIL gap_count: %0d handshakes required 3", hs_cyc.size());
    end else if (hs_cyc[0] != 0 || hs_cyc[1] != 4 || hs_cyc[2] != 8 || end_cyc != 12) begin
      n_errors++;
      $display("FAIL gap_spacing: bytes at %0d,%0d,%0d ready at %0d, required 0,4,8 and 12",
               hs_cyc[0], hs_cyc[1], hs_cyc[2], end_cyc);
    end
    sel = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [47:0] ev; int el; bit es;
    ascii_in = 8'h51; ascii_valid = 1'b1;
    @(negedge clk);
    ascii_valid = 1'b0; code_ready = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (o_cv !== 1'b1 || o_co !== 8'hF0) begin
      n_errors++; $display("FAIL mid_pre: valid=%b code=%h required 1/F0", o_cv, o_co);
    end
    code_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (o_cv !== 1'b0) begin n_errors++; $display("FAIL mid_async_valid: %b required 0", o_cv); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (o_ready !== 1'b1 || o_busy !== 1'b0) begin
      n_errors++; $display("FAIL mid_idle: ready=%b busy=%b required 1/0", o_ready, o_busy);
    end
    run_char(8'h71, 0);
    model(8'h71, ev, el, es);
    n_checks++;
    if (got_vec !== ev || got_len != el) begin
      n_errors++;
      $display("FAIL mid_after_q: got %0d bytes %h, required %0d bytes %h", got_len, got_vec, el, ev);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] chars [4];
    logic [47:0] ev; int el; bit es;
    chars = '{8'h62, 8'h3F, 8'h20, 8'h09};
    foreach (chars[i]) begin
      run_char(chars[i], 0);
      model(chars[i], ev, el, es);
      n_checks++;
      if (got_vec !== ev || got_len != el || first_valid_cyc != 0) begin
        n_errors++;
        $display("FAIL b2b_%h: got %0d bytes %h first at %0d, required %0d bytes %h first at 0",
                 chars[i], got_len, got_vec, first_valid_cyc, el, ev);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0]  ch;
    logic [47:0] ev; int el; bit es;
    for (int n = 0; n < 40; n++) begin
      ch = (n % 4 == 3) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(8'h20, 8'h7E));
      run_char(ch, 2);
      model(ch, ev, el, es);
      n_checks++;
      if (got_vec !== ev || got_len != el) begin
        n_errors++;
        $display("FAIL rand_%h: got %0d bytes %h, required %0d bytes %h", ch, got_len, got_vec, el, ev);
      end
      n_checks++;
      if (unsup_cnt != (es ? 0 : 1)) begin
        n_errors++; $display("FAIL rand_unsup_%h: %0d pulses required %0d", ch, unsup_cnt, es ? 0 : 1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_plain();
    test_shift();
    test_backpressure();
    test_unsupported();
    test_gap();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ascii_kb_code_encoder.md
Name: ascii_kb_code_encoder

Overview:
Converts one ASCII character into the PS/2 Set-2 scan-code byte sequence that a keyboard would send for that keystroke. This includes the Left-Shift make and break codes when the character needs Shift. It sits upstream of the PS/2 device-side transmitter and is driven by the soft processor or a test UART. It is the inverse of the keyboard-side scan-code-to-ASCII conversion path. Characters arrive on a valid/ready interface and leave as one byte per valid/ready handshake.

Parameters:
SHIFT_CODE, 8'h12, make code emitted for Left Shift.
BREAK_PREFIX, 8'hF0, prefix byte that precedes every break code.
GAP_CYCLES, 0, idle cycles inserted after each output byte is accepted (0 = back-to-back). Counter width is clog2(GAP_CYCLES+1), with a minimum of 1.

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
ascii_in  in  8  character to encode
ascii_valid  in  1  ascii_in is valid
ascii_ready  out  1  encoder can accept a character
code_out  out  8  scan-code byte
code_valid  out  1  code_out is valid
code_ready  in  1  downstream accepts code_out
unsupported  out  1  one-cycle pulse: the accepted character has no mapping
busy  out  1  a sequence is in progress (state != IDLE)

Behaviour:
- Interface: one clock, clk; reset is rst_n, asynchronous and active-low. All outputs are registered.
- Reset values: ascii_ready=1, code_valid=0, code_out=8'h00, unsupported=0, busy=0, state=IDLE, gap counter=0.
- Input handshake:
  - ascii_ready=1 only in IDLE.
  - A character is accepted when ascii_valid && ascii_ready. It is latched together with its lookup result {key_code, needs_shift, supported}.
- Unmapped characters:
  - An unmapped character is still accepted.
  - unsupported pulses high on the next cycle; state stays IDLE; no bytes are emitted.
- Mapping:
  - a-z: letter code, no shift. A-Z: same letter code, with shift.
  - 0-9 and the unshifted punctuation ` - = [ ] \ ; ' , . / map to their own keys without shift.
  - Their shifted counterparts ~ ! @ # $ % ^ & * ( ) _ + { } | : " < > ? map to the same keys with shift.
  - Controls: space->29, 0x0A and 0x0D->5A, 0x08->66, 0x09->0D; none use shift.
  - Everything else is unsupported, including all bytes >= 0x7F.
- Sequences:
  - Without shift: key, F0, key.
  - With shift: 12, key, F0, key, F0, 12.
- States: IDLE, SH_MK, KEY_MK, KEY_BP, KEY_BK, SH_BP, SH_BK, GAP.
  - IDLE->SH_MK when needs_shift, else IDLE->KEY_MK.
  - SH_MK->KEY_MK->KEY_BP->KEY_BK.
  - KEY_BK->SH_BP->SH_BK->IDLE when needs_shift; KEY_BK->IDLE otherwise.
  - Each byte state advances only on code_valid && code_ready.
  - When GAP_CYCLES>0, each advance passes through GAP for exactly GAP_CYCLES cycles (code_valid=0), then enters the recorded next state.
- Latency: accept on cycle N; first byte presented with code_valid=1 on cycle N+1. With code_ready held high and GAP_CYCLES=0, one byte is emitted per cycle.
- Output stability: while code_valid=1 && code_ready=0, code_out and code_valid hold. Changing code_ready never drops code_valid.
- Returning to IDLE: ascii_ready rises on the cycle after the final byte is accepted, or after the final gap expires. A new character can therefore be accepted at the earliest one cycle after the last handshake.
- busy tracks state != IDLE and is independent of unsupported.
- Reset mid-sequence: everything returns immediately to reset values. A partial sequence is abandoned; no break codes are emitted for it.
- Changes on ascii_in or ascii_valid while not ready are ignored. The latched character never changes mid-sequence.

Decomposition:
- Shared package kb_codes_pkg holds:
  - localparams for every Set-2 key code used here (KC_A..KC_SPACE, KC_ENTER=8'h5A, KC_BKSP=8'h66, KC_TAB=8'h0D, KC_LSHIFT=8'h12, KC_BREAK=8'hF0);
  - the state enum typedef;
  - the lookup result struct {key_code[7:0], needs_shift, supported}.
  The receive-side converter then shares the same code constants.
- One combinational sub-module, ascii_to_kb_lookup, maps ascii_in to the lookup struct. The top level holds the FSM, gap counter and handshake registers.

Test Plan:
- Reset, then 'a' (0x61) with code_ready=1, GAP_CYCLES=0 -> code_out sequence 1C, F0, 1C on three consecutive cycles; ascii_ready returns to 1 afterwards; unsupported never pulses.
- 'A' (0x41) -> 12, 1C, F0, 1C, F0, 12. Likewise '!' (0x21) -> 12, 16, F0, 16, F0, 12.
- Backpressure: 'z' (0x7A) with code_ready toggling 1,0,0,1,... -> 1A, F0, 1A each held stable while not accepted; no byte is lost or duplicated.
- 0x7F and 0x80 -> each accepted, one-cycle unsupported pulse, no code_valid, busy stays 0.
- GAP_CYCLES=3, input 0x0A -> 5A, 3 idle cycles, F0, 3 idle cycles, 5A, 3 idle cycles, then ascii_ready=1.
- Assert rst_n low during KEY_BP of 'Q' (0x51) -> code_valid drops asynchronously; after release, state is IDLE and ascii_ready=1; the next 'q' yields exactly 15, F0, 15.
